// File: rtl/gray_run_ctrl_pkg.sv
// gray_run_ctrl_pkg: shared widths, FSM encodings, counter-select bit
// indices and the binary-to-Gray helper for the Gray run controller.
package gray_run_ctrl_pkg;

  localparam int W4_DEF     = 4;
  localparam int W3_DEF     = 3;
  localparam int LEN_W_DEF  = 8;
  localparam int GRAY_MAX_W = 8;

  localparam int SEL_G4 = 0;
  localparam int SEL_G3 = 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Callers zero-extend narrower values in and truncate the result back.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_run_ctrl_if.sv
// gray_run_ctrl_if: host-side bundle of the Gray run controller.
//   master (host): drives start, steps, sel, hold, clear;
//                  observes gray_4, gray_3, busy, done, wrap_4, wrap_3, remaining.
//   slave  (controller): the mirror image.
interface gray_run_ctrl_if
  import gray_run_ctrl_pkg::*;
#(
  parameter int W4    = W4_DEF,
  parameter int W3    = W3_DEF,
  parameter int LEN_W = LEN_W_DEF
);
  logic             start;
  logic [LEN_W-1:0] steps;
  logic [1:0]       sel;
  logic             hold;
  logic             clear;
  logic [W4-1:0]    gray_4;
  logic [W3-1:0]    gray_3;
  logic             busy;
  logic             done;
  logic             wrap_4;
  logic             wrap_3;
  logic [LEN_W-1:0] remaining;

  modport master (
    output start, steps, sel, hold, clear,
    input  gray_4, gray_3, busy, done, wrap_4, wrap_3, remaining
  );

  modport slave (
    input  start, steps, sel, hold, clear,
    output gray_4, gray_3, busy, done, wrap_4, wrap_3, remaining
  );
endinterface

// File: rtl/gray_run_ctrl_step_counter.sv
// gray_step_counter: W-bit Gray counter advancing one code per enabled cycle.
//   clk, reset : clock, synchronous active-high reset
//   en         : advance one Gray step this cycle
//   clr        : zero the counter (never raises wrap)
//   gray       : registered Gray value
//   wrap       : one-cycle pulse while gray shows zero after rolling over
module gray_step_counter
  import gray_run_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] gray,
  output logic         wrap
);

  logic [W-1:0] bin_q;
  logic [W-1:0] bin_nxt;
  logic [W-1:0] gray_q;
  logic         wrap_q;

  assign bin_nxt = bin_q + W'(1);

  // Gray is registered from the next binary value so the output never
  // passes through XOR glitches.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else if (en) begin
      bin_q  <= bin_nxt;
      gray_q <= W'(bin2gray(GRAY_MAX_W'(bin_nxt)));
      wrap_q <= &bin_q;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/gray_run_ctrl.sv
// gray_run_ctrl: runs bursts of Gray-counter advances on a 4-bit and a
// 3-bit counter. An accepted start latches the step count and counter
// select; each un-held RUN cycle advances the selected counters once.
//   clk, reset : clock, synchronous active-high reset
//   bus        : gray_run_ctrl_if slave (start/steps/sel/hold/clear in;
//                gray_4/gray_3/busy/done/wrap_4/wrap_3/remaining out)
//
// state | meaning
// IDLE  | waiting for start; clear honoured here
// RUN   | one advance per cycle with hold low
// DONE  | single-cycle done pulse, returns to IDLE
module gray_run_ctrl
  import gray_run_ctrl_pkg::*;
#(
  parameter int W4    = W4_DEF,
  parameter int W3    = W3_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  gray_run_ctrl_if.slave   bus
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [1:0]       sel_q, sel_d;
  logic             adv;
  logic             clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    adv     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        clr = bus.clear;
        if (bus.start) begin
          if (bus.steps != '0) begin
            rem_d   = bus.steps;
            sel_d   = bus.sel;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (!bus.hold) begin
          adv   = 1'b1;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  gray_step_counter #(.W(W4)) u_g4 (
    .clk   (clk),
    .reset (reset),
    .en    (adv & sel_q[SEL_G4]),
    .clr   (clr),
    .gray  (bus.gray_4),
    .wrap  (bus.wrap_4)
  );

  gray_step_counter #(.W(W3)) u_g3 (
    .clk   (clk),
    .reset (reset),
    .en    (adv & sel_q[SEL_G3]),
    .clr   (clr),
    .gray  (bus.gray_3),
    .wrap  (bus.wrap_3)
  );

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.remaining = rem_q;

endmodule

// File: tb/tb_gray_run_ctrl.sv
// tb_gray_run_ctrl: scoreboard bench for gray_run_ctrl. Each stimulus cycle
// updates a behavioural model and pushes the expected output word; the
// scenario tasks pop and compare after the clock edge.
module tb_gray_run_ctrl;

  logic clk;
  logic reset;

  gray_run_ctrl_if #(.W4(4), .W3(3), .LEN_W(8)) bus ();

  gray_run_ctrl #(.W4(4), .W3(3), .LEN_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {gray_4, gray_3, busy, done, wrap_4, wrap_3, remaining}
  typedef logic [18:0] vec_t;

  vec_t sb[$];
  int   vecs = 0;
  int   errs = 0;

  int         m_state;
  logic [7:0] m_rem;
  logic [1:0] m_sel;
  logic [3:0] m_b4;
  logic [2:0] m_b3;

  function automatic vec_t observe();
    return {bus.gray_4, bus.gray_3, bus.busy, bus.done, bus.wrap_4, bus.wrap_3, bus.remaining};
  endfunction

  // Drive one cycle of inputs, advance the model, push expectation, clock.
  task automatic step(input logic st, input logic [7:0] stp, input logic [1:0] sl,
                      input logic hd, input logic cl, input logic rs);
    logic w4, w3;
    logic [3:0] g4;
    logic [2:0] g3;
    reset     = rs;
    bus.start = st;
    bus.steps = stp;
    bus.sel   = sl;
    bus.hold  = hd;
    bus.clear = cl;
    w4 = 1'b0;
    w3 = 1'b0;
    if (rs) begin
      m_state = 0; m_rem = 0; m_sel = 0; m_b4 = 0; m_b3 = 0;
    end else begin
      case (m_state)
        0: begin
          if (cl) begin m_b4 = 0; m_b3 = 0; end
          if (st) begin
            if (stp != 0) begin m_rem = stp; m_sel = sl; m_state = 1; end
            else m_state = 2;
          end
        end
        1: if (!hd) begin
          if (m_sel[0]) begin w4 = (m_b4 == 4'hF); m_b4 = m_b4 + 4'd1; end
          if (m_sel[1]) begin w3 = (m_b3 == 3'h7); m_b3 = m_b3 + 3'd1; end
          m_rem = m_rem - 8'd1;
          if (m_rem == 0) m_state = 2;
        end
        default: m_state = 0;
      endcase
    end
    g4 = m_b4 ^ (m_b4 >> 1);
    g3 = m_b3 ^ (m_b3 >> 1);
    sb.push_back({g4, g3, (m_state != 0), (m_state == 2), w4, w3, m_rem});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t e, o;
    for (int i = 0; i < 2; i++) begin
      step(0, 8'd0, 2'b00, 0, 0, 1);
      e = sb.pop_front(); o = observe(); vecs++;
      if (o !== e) begin errs++; $display("FAIL reset[%0d] got %h want %h", i, o, e); end
    end
    vecs++;
    if (observe() !== 19'd0) begin errs++; $display("FAIL reset_zero got %h want 0", observe()); end
    step(0, 8'd0, 2'b00, 0, 0, 0);
    e = sb.pop_front(); o = observe(); vecs++;
    if (o !== e) begin errs++; $display("FAIL reset_release got %h want %h", o, e); end
  endtask

  task automatic test_run5();
    logic [3:0] seq4 [5] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
    logic [2:0] seq3 [5] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111};
    vec_t e, o;
    int busy_n = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) step(1, 8'd5, 2'b11, 0, 0, 0);
      else        step(0, 8'd0, 2'b00, 0, 0, 0);
      e = sb.pop_front(); o = observe(); vecs++;
      if (o !== e) begin errs++; $display("FAIL run5[%0d] got %h want %h", i, o, e); end
      if (bus.busy) busy_n++;
      if (i >= 1 && i <= 5) begin
        vecs++;
        if (bus.gray_4 !== seq4[i-1] || bus.gray_3 !== seq3[i-1]) begin
          errs++;
          $display("FAIL run5_seq[%0d] got %b/%b want %b/%b", i, bus.gray_4, bus.gray_3, seq4[i-1], seq3[i-1]);
        end
      end
    end
    vecs++;
    if (busy_n != 6) begin errs++; $display("FAIL run5_busy got %0d want 6", busy_n); end
  endtask

  // Full wrap of one counter; the other must stay put with no wrap.
  task automatic test_wrap(input logic [7:0] n, input logic [1:0] sl);
    vec_t e, o;
    int w4_n = 0, w3_n = 0;
    step(1, 1'b0 ? 8'd0 : 8'd0, 2'b00, 0, 1, 0);  // clear in IDLE + zero-step run
    e = sb.pop_front(); o = observe(); vecs++;
    if (o !== e) begin errs++; $display("FAIL wrap_clr got %h want %h", o, e); end
    step(0, 8'd0, 2'b00, 0, 0, 0);
    e = sb.pop_front(); o = observe(); vecs++;
    if (o !== e) begin errs++; $display("FAIL wrap_done got %h want %h", o, e); end
    for (int i = 0; i <= int'(n) + 1; i++) begin
      if (i == 0) step(1, n, sl, 0, 0, 0);
      else        step(0, 8'd0, 2'b00, 0, 0, 0);
      e = sb.pop_front(); o = observe(); vecs++;
      if (o !== e) begin errs++; $display("FAIL wrap_sel%b[%0d] got %h want %h", sl, i, o, e); end
      if (bus.wrap_4) w4_n++;
      if (bus.wrap_3) w3_n++;
      if (i == int'(n)) begin
        vecs++;
        if (bus.gray_4 !== 4'd0 || bus.gray_3 !== 3'd0 || bus.wrap_4 !== sl[0] || bus.wrap_3 !== sl[1]) begin
          errs++;
          $display("FAIL wrap_last got g4=%b g3=%b w=%b%b want 0/0 w=%b%b",
                   bus.gray_4, bus.gray_3, bus.wrap_4, bus.wrap_3, sl[0], sl[1]);
        end
      end
    end
    vecs++;
    if (w4_n != int'(sl[0]) || w3_n != int'(sl[1])) begin
      errs++; $display("FAIL wrap_count got %0d/%0d want %0d/%0d", w4_n, w3_n, sl[0], sl[1]);
    end
  endtask

  task automatic test_hold();
    vec_t e, o;
    int busy_n = 0, done_at = -1;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) step(1, 8'd4, 2'b11, 0, 0, 0);
      else        step(0, 8'd0, 2'b00, (i >= 3 && i <= 5), 0, 0);
      e = sb.pop_front(); o = observe(); vecs++;
      if (o !== e) begin errs++; $display("FAIL hold[%0d] got %h want %h", i, o, e); end
      if (bus.busy) busy_n++;
      if (bus.done) done_at = i;
      if (i >= 3 && i <= 5) begin
        vecs++;
        if (bus.remaining !== 8'd2) begin errs++; $display("FAIL hold_rem[%0d] got %0d want 2", i, bus.remaining); end
      end
    end
    vecs++;
    if (busy_n != 8 || done_at != 7) begin
      errs++; $display("FAIL hold_timing got busy=%0d done_at=%0d want 8/7", busy_n, done_at);
    end
  endtask

  task automatic test_zero_and_ignored_start();
    vec_t e, o;
    step(1, 8'd0, 2'b11, 0, 0, 0);
    e = sb.pop_front(); o = observe(); vecs++;
    if (o !== e) begin errs++; $display("FAIL zero_steps got %h want %h", o, e); end
    step(0, 8'd0, 2'b00, 0, 0, 0);
    e = sb.pop_front(); o = observe(); vecs++;
    if (o !== e) begin errs++; $display("FAIL zero_idle got %h want %h", o, e); end
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      step(1, 8'd3, 2'b01, 0, 0, 0);
      else if (i <= 2) step(1, 8'd7, 2'b10, 0, 1, 0);  // start/clear mid-run ignored
      else             step(0, 8'd0, 2'b00, 0, 0, 0);
      e = sb.pop_front(); o = observe(); vecs++;
      if (o !== e) begin errs++; $display("FAIL ignore_start[%0d] got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_reset_mid_run_and_clear();
    vec_t e, o;
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      step(1, 8'd5, 2'b11, 0, 0, 0);
      else if (i == 3) step(0, 8'd0, 2'b00, 0, 0, 1);
      else             step(0, 8'd0, 2'b00, 0, 0, 0);
      e = sb.pop_front(); o = observe(); vecs++;
      if (o !== e) begin errs++; $display("FAIL mid_reset[%0d] got %h want %h", i, o, e); end
      if (i >= 3) begin
        vecs++;
        if (observe() !== 19'd0) begin errs++; $display("FAIL mid_reset_zero[%0d] got %h want 0", i, observe()); end
      end
    end
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      step(1, 8'd3, 2'b11, 0, 0, 0);
      else if (i == 5) step(0, 8'd0, 2'b00, 0, 1, 0);
      else             step(0, 8'd0, 2'b00, 0, 0, 0);
      e = sb.pop_front(); o = observe(); vecs++;
      if (o !== e) begin errs++; $display("FAIL clear[%0d] got %h want %h", i, o, e); end
    end
    vecs++;
    if (bus.gray_4 !== 4'd0 || bus.gray_3 !== 3'd0 || bus.wrap_4 || bus.wrap_3) begin
      errs++; $display("FAIL clear_final got g4=%b g3=%b w=%b%b want zeros", bus.gray_4, bus.gray_3, bus.wrap_4, bus.wrap_3);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.steps = '0; bus.sel = '0; bus.hold = 1'b0; bus.clear = 1'b0;
    m_state = 0; m_rem = 0; m_sel = 0; m_b4 = 0; m_b3 = 0;
    test_reset();
    test_run5();
    test_wrap(8'd16, 2'b01);
    test_wrap(8'd8, 2'b10);
    test_hold();
    test_zero_and_ignored_start();
    test_reset_mid_run_and_clear();
    if (sb.size() != 0) begin errs++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
